// File: rtl/hash_serializer_if.sv
// hash_serializer_if: hash start handshake and word-write port of the hash serializer
interface hash_serializer_if #(
    parameter int HASH_LENGTH = 8
);
    localparam int AW = $clog2(HASH_LENGTH);
    logic                      hash_vector_valid;
    logic [32*HASH_LENGTH-1:0] hash_vector;
    logic                      hash_ready;
    logic                      write_stall;
    logic                      hash_write;
    logic [AW-1:0]             hash_address;
    logic [31:0]               hash_data;
    logic                      hash_write_complete;
    modport master (
        input  hash_vector_valid, hash_vector, write_stall,
        output hash_ready, hash_write, hash_address, hash_data, hash_write_complete
    );
    modport slave (
        output hash_vector_valid, hash_vector, write_stall,
        input  hash_ready, hash_write, hash_address, hash_data, hash_write_complete
    );
endinterface

// File: rtl/hash_serializer.sv
// hash_serializer: writes a captured hash vector out as HASH_LENGTH 32-bit words, one per unstalled cycle
module hash_serializer #(
    parameter int HASH_LENGTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    hash_serializer_if.master bus
);
    localparam int AW = $clog2(HASH_LENGTH);
    localparam logic [AW-1:0] LAST = AW'(HASH_LENGTH - 1);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t                    state, state_n;
    logic [AW-1:0]             count, count_n, address_n;
    logic [32*HASH_LENGTH-1:0] shadow, shadow_n;
    logic [31:0]               data_n;
    logic                      ready_n, write_n, complete_n;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                   <= IDLE;
            count                   <= '0;
            shadow                  <= '0;
            bus.hash_ready          <= 1'b1;
            bus.hash_write          <= 1'b0;
            bus.hash_address        <= '0;
            bus.hash_data           <= '0;
            bus.hash_write_complete <= 1'b0;
        end else begin
            state                   <= state_n;
            count                   <= count_n;
            shadow                  <= shadow_n;
            bus.hash_ready          <= ready_n;
            bus.hash_write          <= write_n;
            bus.hash_address        <= address_n;
            bus.hash_data           <= data_n;
            bus.hash_write_complete <= complete_n;
        end
    end
    // Address/data only move when a word is issued; abort leaves them holding.
    always_comb begin
        state_n    = state;
        count_n    = count;
        shadow_n   = shadow;
        address_n  = bus.hash_address;
        data_n     = bus.hash_data;
        ready_n    = 1'b0;
        write_n    = 1'b0;
        complete_n = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            count_n = '0;
            ready_n = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ready_n = !bus.hash_vector_valid;
                    if (bus.hash_vector_valid) begin
                        shadow_n = bus.hash_vector;
                        count_n  = '0;
                        state_n  = WRITE;
                    end
                end
                WRITE: begin
                    if (!bus.write_stall) begin
                        write_n   = 1'b1;
                        address_n = count;
                        data_n    = shadow[32*count +: 32];
                        count_n   = (count == LAST) ? '0 : count + 1'b1;
                        state_n   = (count == LAST) ? DONE : WRITE;
                    end
                end
                DONE: begin
                    complete_n = 1'b1;
                    ready_n    = 1'b1;
                    state_n    = IDLE;
                end
                default: begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hash_serializer.sv
// tb_hash_serializer: directed vectors against hand-computed word streams for hash_serializer
module tb_hash_serializer;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    int checks = 0;
    int failures = 0;
    int n_writes = 0;
    int n_completes = 0;
    localparam logic [255:0] V1 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] V2 = 256'h01234567_89abcdef_fedcba98_76543210_deadbeef_cafef00d_0badc0de_13579bdf;
    hash_serializer_if #(.HASH_LENGTH(8)) bus ();
    hash_serializer #(.HASH_LENGTH(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .bus    (bus.master)
    );
    always #5 clock = ~clock;
    always @(negedge clock) begin
        if (bus.hash_write) n_writes++;
        if (bus.hash_write_complete) n_completes++;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clock);
        #1;
    endtask
    // Starts a sequence at E0 and checks every word edge plus the completion edge.
    task automatic run_seq(input string tag, input logic [255:0] vec, input logic [31:0] stall_mask,
                           input bit perturb, input bit hold_valid);
        int w = 0;
        int k = 0;
        bus.hash_vector = vec;
        bus.hash_vector_valid = 1'b1;
        tick;
        check({tag, ".ready_lo"}, 32'(bus.hash_ready), 32'd0);
        check({tag, ".idle_write"}, 32'(bus.hash_write), 32'd0);
        while (w < 8 && k < 20) begin
            k++;
            bus.write_stall = stall_mask[k];
            bus.hash_vector_valid = hold_valid || (perturb && k == 3);
            if (perturb && k == 3) bus.hash_vector = '1;
            tick;
            if (bus.write_stall) begin
                check($sformatf("%s.stall_write%0d", tag, k), 32'(bus.hash_write), 32'd0);
                check($sformatf("%s.stall_addr%0d", tag, k), 32'(bus.hash_address), 32'(w - 1));
            end else begin
                check($sformatf("%s.write%0d", tag, w), 32'(bus.hash_write), 32'd1);
                check($sformatf("%s.addr%0d", tag, w), 32'(bus.hash_address), 32'(w));
                check($sformatf("%s.data%0d", tag, w), bus.hash_data, vec[32*w +: 32]);
                check($sformatf("%s.busy%0d", tag, w), 32'(bus.hash_ready), 32'd0);
                w++;
            end
        end
        check({tag, ".words"}, 32'(w), 32'd8);
        bus.write_stall = 1'b0;
        bus.hash_vector_valid = hold_valid;
        tick;
        check({tag, ".complete"}, 32'(bus.hash_write_complete), 32'd1);
        check({tag, ".ready_back"}, 32'(bus.hash_ready), 32'd1);
        check({tag, ".done_write"}, 32'(bus.hash_write), 32'd0);
    endtask
    initial begin
        int w0;
        int c0;
        bus.hash_vector_valid = 1'b0;
        bus.hash_vector = '0;
        bus.write_stall = 1'b0;
        repeat (2) tick;
        check("rst.ready", 32'(bus.hash_ready), 32'd1);
        check("rst.write", 32'(bus.hash_write), 32'd0);
        check("rst.addr", 32'(bus.hash_address), 32'd0);
        check("rst.data", bus.hash_data, 32'd0);
        check("rst.complete", 32'(bus.hash_write_complete), 32'd0);
        reset = 1'b1;
        enable = 1'b1;
        tick;
        run_seq("basic", V1, 32'h0, 1'b0, 1'b0);
        check("basic.last_data", bus.hash_data, 32'h6a09e667);
        check("basic.last_addr", 32'(bus.hash_address), 32'd7);
        tick;
        check("basic.pulse_end", 32'(bus.hash_write_complete), 32'd0);
        check("basic.idle_ready", 32'(bus.hash_ready), 32'd1);
        run_seq("stall", V1, 32'h18, 1'b0, 1'b0);
        tick;
        run_seq("perturb", V1, 32'h0, 1'b1, 1'b0);
        tick;
        check("perturb.no_restart_ready", 32'(bus.hash_ready), 32'd1);
        tick;
        check("perturb.no_restart_write", 32'(bus.hash_write), 32'd0);
        bus.hash_vector = V1;
        bus.hash_vector_valid = 1'b1;
        tick;
        bus.hash_vector_valid = 1'b0;
        repeat (3) tick;
        check("abort.pre_write", 32'(bus.hash_write), 32'd1);
        check("abort.pre_addr", 32'(bus.hash_address), 32'd2);
        enable = 1'b0;
        tick;
        check("abort.write", 32'(bus.hash_write), 32'd0);
        check("abort.ready", 32'(bus.hash_ready), 32'd1);
        c0 = n_completes;
        repeat (4) begin
            tick;
            check("abort.complete", 32'(bus.hash_write_complete), 32'd0);
            check("abort.idle_write", 32'(bus.hash_write), 32'd0);
        end
        enable = 1'b1;
        tick;
        check("abort.pulses", 32'(n_completes - c0), 32'd0);
        run_seq("restart", V2, 32'h0, 1'b0, 1'b0);
        tick;
        bus.hash_vector = V1;
        bus.hash_vector_valid = 1'b1;
        tick;
        bus.hash_vector_valid = 1'b0;
        repeat (4) tick;
        check("areset.pre_addr", 32'(bus.hash_address), 32'd3);
        #3 reset = 1'b0;
        #1;
        check("areset.ready", 32'(bus.hash_ready), 32'd1);
        check("areset.write", 32'(bus.hash_write), 32'd0);
        check("areset.addr", 32'(bus.hash_address), 32'd0);
        check("areset.data", bus.hash_data, 32'd0);
        check("areset.complete", 32'(bus.hash_write_complete), 32'd0);
        #2 reset = 1'b1;
        w0 = n_writes;
        repeat (12) tick;
        check("areset.no_writes", 32'(n_writes - w0), 32'd0);
        check("areset.idle_ready", 32'(bus.hash_ready), 32'd1);
        w0 = n_writes;
        c0 = n_completes;
        run_seq("b2b0", V1, 32'h0, 1'b0, 1'b1);
        run_seq("b2b1", V2, 32'h0, 1'b0, 1'b1);
        bus.hash_vector_valid = 1'b0;
        tick;
        check("b2b.writes", 32'(n_writes - w0), 32'd16);
        check("b2b.pulses", 32'(n_completes - c0), 32'd2);
        check("b2b.ready", 32'(bus.hash_ready), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
